// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package serial_adder_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// One-bit combinational full adder used by the serial adder datapath.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: adds one operand bit per cycle, LSB first, through a single full adder.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_e           state_r;
    state_e           state_s;
    logic             load_s;
    logic             shift_s;
    logic             last_s;
    logic [WIDTH-1:0] a_sr_r;
    logic [WIDTH-1:0] b_sr_r;
    logic [WIDTH-1:0] sum_r;
    logic             carry_r;
    logic             cout_r;
    logic             ovf_r;
    logic             busy_r;
    logic             done_r;
    logic [CW-1:0]    cnt_r;
    logic             fa_sum_s;
    logic             fa_cout_s;

    full_adder u_fa (
        .a    (a_sr_r[0]),
        .b    (b_sr_r[0]),
        .cin  (carry_r),
        .s    (fa_sum_s),
        .cout (fa_cout_s)
    );

    assign last_s = (cnt_r == CNT_LAST);

    // Next-state decode plus load/shift strobes for the datapath
    always_comb begin
        state_s = state_r;
        load_s  = 1'b0;
        shift_s = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_s = ST_RUN;
                    load_s  = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                shift_s = 1'b1;
                if (last_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register with status flags registered from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == ST_RUN);
            done_r  <= (state_s == ST_DONE);
        end
    end

    // Operand shift registers, carry, bit counter and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr_r  <= '0;
            b_sr_r  <= '0;
            sum_r   <= '0;
            carry_r <= 1'b0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
            cnt_r   <= '0;
        end else if (load_s) begin
            a_sr_r  <= a;
            b_sr_r  <= b;
            carry_r <= cin;
            cnt_r   <= '0;
        end else if (shift_s) begin
            a_sr_r  <= {1'b0, a_sr_r[WIDTH-1:1]};
            b_sr_r  <= {1'b0, b_sr_r[WIDTH-1:1]};
            sum_r   <= {fa_sum_s, sum_r[WIDTH-1:1]};
            carry_r <= fa_cout_s;
            cnt_r   <= cnt_r + CNT_ONE;
            // On the MSB cycle carry_r is the carry into the MSB
            if (last_s) begin
                cout_r <= fa_cout_s;
                ovf_r  <= carry_r ^ fa_cout_s;
            end
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign sum  = sum_r;
    assign cout = cout_r;
    assign ovf  = ovf_r;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed corner cases plus randomized operations
// checked against an arithmetic reference model.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int n_cmp;
    int n_err;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd_w();
        logic [31:0] r;
        r = $urandom;
        return r[W-1:0];
    endfunction

    function automatic logic rnd_b();
        logic [31:0] r;
        r = $urandom;
        return r[0];
    endfunction

    // Reference: {ovf, cout, sum} from plain integer addition and sign rules
    function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic mc);
        logic [W:0] full;
        logic       v;
        full = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
        v = (ma[W-1] == mb[W-1]) && (full[W-1] != ma[W-1]);
        return {v, full[W], full[W-1:0]};
    endfunction

    task automatic check_result(input string tag, input logic [W-1:0] ea, input logic [W-1:0] eb,
                                input logic ec);
        logic [W+1:0] e;
        e = model(ea, eb, ec);
        chk({tag, "_sum"},  32'(sum),  32'(e[W-1:0]));
        chk({tag, "_cout"}, 32'(cout), 32'(e[W]));
        chk({tag, "_ovf"},  32'(ovf),  32'(e[W+1]));
    endtask

    // One operation; inj>0 raises start (with a=FF) during RUN cycle inj to test that it is ignored
    task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tc, input int inj);
        int lat;
        int early;
        start = 1'b1;
        a = ta;
        b = tb;
        cin = tc;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = rnd_w();
        b = rnd_w();
        cin = rnd_b();
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        lat = 0;
        early = 0;
        while (done !== 1'b1 && lat < W + 4) begin
            if (busy !== 1'b1) early++;
            start = (inj > 0 && lat == inj - 1) ? 1'b1 : 1'b0;
            if (start) a = 8'hFF;
            @(posedge clk);
            #1;
            start = 1'b0;
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(W));
        chk({tag, "_busy_gap"}, 32'(early), 32'd0);
        chk({tag, "_busy_in_done"}, 32'(busy), 32'd0);
        check_result(tag, ta, tb, tc);
        @(posedge clk);
        #1;
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check_result({tag, "_hold"}, ta, tb, tc);
    endtask

    initial begin
        int gap;
        int seen;
        logic [W-1:0] ca;
        logic [W-1:0] cb;
        logic         cc;
        logic [W-1:0] na;
        logic [W-1:0] nb;
        logic         nc;

        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum",  32'(sum),  32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_ovf",  32'(ovf),  32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op("add_0f_01", 8'h0F, 8'h01, 1'b0, 0);
        run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 0);
        run_op("add_ff_00c", 8'hFF, 8'h00, 1'b1, 0);
        run_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 0);
        run_op("add_80_80", 8'h80, 8'h80, 1'b0, 0);

        // Reset in the middle of a run: outputs clear at once and no done follows
        start = 1'b1;
        a = 8'h55;
        b = 8'h2A;
        cin = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_sum",  32'(sum),  32'd0);
        chk("mid_rst_cout", 32'(cout), 32'd0);
        chk("mid_rst_ovf",  32'(ovf),  32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        seen = 0;
        repeat (W + 3) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        chk("mid_rst_no_done", 32'(seen), 32'd0);
        run_op("post_rst", 8'h01, 8'h01, 1'b0, 0);

        run_op("start_in_run", 8'h12, 8'h34, 1'b0, 3);

        for (int i = 0; i < 30; i++) begin
            run_op("rand", rnd_w(), rnd_w(), rnd_b(), (i % 5 == 0) ? 1 + (i % 7) : 0);
            gap = $urandom_range(0, 3);
            repeat (gap) @(posedge clk);
            #1;
        end

        // start held high: one result every W+1 cycles
        ca = rnd_w();
        cb = rnd_w();
        cc = rnd_b();
        start = 1'b1;
        a = ca;
        b = cb;
        cin = cc;
        @(posedge clk);
        #1;
        for (int op = 0; op < 6; op++) begin
            na = rnd_w();
            nb = rnd_w();
            nc = rnd_b();
            a = na;
            b = nb;
            cin = nc;
            seen = 0;
            repeat (W - 1) begin
                @(posedge clk);
                #1;
                if (done === 1'b1) seen++;
            end
            @(posedge clk);
            #1;
            chk("b2b_early_done", 32'(seen), 32'd0);
            chk("b2b_done", 32'(done), 32'd1);
            check_result("b2b", ca, cb, cc);
            ca = na;
            cb = nb;
            cc = nc;
            @(posedge clk);
            #1;
            chk("b2b_restart_busy", 32'(busy), 32'd1);
        end
        start = 1'b0;
        repeat (W + 2) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
